data_mem_responder: RTL

//  Responder end of the core's data-memory interface: serves load/store requests
//  (from MemWrite/MemToReg decode) against an internal word RAM with fixed,

---
 rtl/data_mem_if.sv | 16 +
 rtl/data_mem_responder.sv | 57 +++++
 2 files changed

// File: rtl/data_mem_if.sv
// data_mem_if: core <-> data-memory request/response bus
interface data_mem_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall;
  modport master (output req_valid, req_write, req_addr, req_wdata,
                  input req_ready, rsp_valid, rsp_rdata, rsp_err, stall);
  modport slave (input req_valid, req_write, req_addr, req_wdata,
                 output req_ready, rsp_valid, rsp_rdata, rsp_err, stall);
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency word RAM serving core load/store requests
module data_mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input logic       clk,
  input logic       reset,
  data_mem_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t      state, state_n;
  logic [3:0]  cnt;
  logic        wr;
  logic [31:0] addr, wdata, rdata;
  logic        err, rerr, done;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH];
  always_comb begin
    idx     = addr[AW+1:2];
    err     = (|addr[1:0]) || (|addr[31:AW+2]);
    done    = state == BUSY && cnt == 4'(LATENCY - 1);
    state_n = state == IDLE ? (bus.req_valid ? BUSY : IDLE) :
              state == BUSY ? (done ? RESP : BUSY) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      rdata <= '0;
      rerr  <= 1'b0;
      wr    <= 1'b0;
      addr  <= '0;
      wdata <= '0;
    end else begin
      state <= state_n;
      cnt   <= state == BUSY ? cnt + 4'd1 : 4'd0;
      if (state == IDLE && bus.req_valid) begin
        wr    <= bus.req_write;
        addr  <= bus.req_addr;
        wdata <= bus.req_wdata;
      end
      if (done) begin
        rdata <= (wr || err) ? 32'd0 : mem[idx];
        rerr  <= err;
      end
    end
  end
  // RAM is never cleared; errored or abandoned stores leave it untouched
  always_ff @(posedge clk)
    if (!reset && done && wr && !err) mem[idx] <= wdata;
  assign bus.req_ready = state == IDLE;
  assign bus.stall     = state == BUSY;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_rdata = rdata;
  assign bus.rsp_err   = rerr;
endmodule
